axi_to_fifo: RTL
================

// Module: axi_to_fifo
// PURPOSE
//  Read-DMA engine: fetches a byte range from memory over AXI4 read (AR/R) and pushes the words into a FIFO write port.
//  Read-side counterpart of the RX FIFO-to-AXI write path; feeds the TX data FIFO of the SP TX unit.
//  Started by a TX command with addr/len (RX DMA-start style); exposes busy/error for a status command.
// PARAMETERS
//  AXI_ADDR_WIDTH   32  address width (araddr, addr)
//  AXI_DATA_WIDTH   64  rdata / FIFO word width; power of two, 32..1024
//  MAX_BURST_BEATS  16  max beats per AR burst; power of two, 1..256
// PORTS
//  clk         in   1      sole clock
//  rst         in   1      asynchronous, active-high reset
//  start       in   1      1-cycle pulse: begin transfer (sampled only when !busy)
//  addr        in   AW     start byte address; must be AXI_DATA_WIDTH/8 aligned
//  len         in   16     length in bytes
//  busy        out  1      transfer in progress
//  error       out  1      sticky RRESP error of last transfer (see CONFIGURATION)
//  araddr      out  AW     AR address
//  arlen       out  8      beats-1
//  arsize      out  3      $clog2(AXI_DATA_WIDTH/8), constant
//  arburst     out  2      2'b01 INCR, constant
//  arvalid     out  1      AR valid
//  arready     in   1      AR ready
//  rdata       in   DW     R data
//  rresp       in   2      R response
//  rlast       in   1      last beat of burst
//  rvalid      in   1      R valid
//  rready      out  1      R ready
//  fifo_wr_en  out  1      FIFO push
//  fifo_wr_data out DW     FIFO data (= rdata of accepted beat)
//  fifo_full   in   1      FIFO full
// BEHAVIOUR
//  Reset (async): state IDLE; busy, error, arvalid, fifo_wr_en = 0; araddr, arlen = 0.
//  beats = ceil(len / BYTES), BYTES = AXI_DATA_WIDTH/8; counter width 17-$clog2(BYTES).
//  IDLE: start & !busy & len!=0 -> latch addr, beats; busy=1 next cycle; go ADDR. len==0: ignored, busy stays 0.
//  ADDR: arvalid=1; araddr = cur addr; arlen = n-1, n = min(remaining, MAX_BURST_BEATS, beats to next 4 KiB boundary).
//   araddr/arlen stable while arvalid & !arready. On arvalid&arready -> DATA; cur addr += n*BYTES; remaining -= n.
//  DATA: rready = !fifo_full, combinational. Beat accepted on rvalid&rready; fifo_wr_en = 1 that cycle with fifo_wr_data = rdata.
//   No push while fifo_full; no beat lost or duplicated.
//   rlast accepted: remaining!=0 -> ADDR next cycle; remaining==0 -> IDLE, busy=0 next cycle.
//  Exactly one burst outstanding; next AR not issued before rlast of the current burst.
//  Trailing bytes beyond len in the last word are pushed unmodified; the consumer trims by len.
//  start while busy: ignored, no effect on the running transfer.
//  rst mid-transfer: immediate return to reset values; the outstanding burst is abandoned (system reset only).
// CONFIGURATION
//  AXI_TO_FIFO_RRESP_CHECK_EN defined: any accepted beat with rresp!=2'b00 sets error.
//   error is sticky until the next accepted start, which clears it. The transfer always runs to completion.
//  Undefined: rresp ignored; error tied 0.
// STRUCTURE
//  Shared package axi_pkg: AXI_BURST_INCR, AXI_RESP_OKAY, AXI_4K_BOUNDARY, state enum axi_to_fifo_state_t {IDLE, ADDR, DATA}.
//  Sub-module axi_burst_splitter (combinational): (cur addr, remaining) -> n.
//  Top module holds the FSM, counters and handshakes.
// TESTING (DW=64, MAX_BURST_BEATS=16, addr/data checked by memory model)
//  start addr=0x1000 len=64 -> one AR araddr=0x1000 arlen=7 arsize=3 arburst=1; 8 pushes in order; busy 0 after rlast.
//  addr=0x2000 len=200 -> AR arlen=15 @0x2000, then AR arlen=8 @0x2080; 25 pushes total.
//  addr=0x1FC0 len=128 -> AR arlen=7 @0x1FC0, then AR arlen=7 @0x2000 (no 4 KiB crossing).
//  fifo_full held 10 cycles mid-burst, rvalid high -> rready=0, no pushes; resumes with no loss or duplication.
//  rresp=SLVERR on beat 3 -> macro on: error=1 after done, cleared on next start; macro off: error=0.
//  len=0 start -> no AR, busy stays 0; start pulse while busy -> ignored; rst mid-DATA -> outputs 0 that cycle.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI constants and the axi_to_fifo state encoding.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam int unsigned AXI_4K_BOUNDARY = 4096;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } axi_to_fifo_state_t;

endpackage

// File: rtl/axi_burst_splitter.sv
// Picks the beat count of the next AR burst: min(remaining, MAX_BURST_BEATS, beats to next 4 KiB).
module axi_burst_splitter
  import axi_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH  = 64,
  parameter int unsigned MAX_BURST_BEATS = 16,
  parameter int unsigned CNT_WIDTH       = 14
) (
  input  logic [11:0]          page_off,
  input  logic [CNT_WIDTH-1:0] remaining,
  output logic [8:0]           n
);

  localparam int unsigned OFF = $clog2(AXI_DATA_WIDTH / 8);

  logic [12:0] bytes_to_4k;
  logic [16:0] beats_to_4k;
  logic [16:0] rem_ext;
  logic [16:0] lim;

  assign bytes_to_4k = 13'(AXI_4K_BOUNDARY) - {1'b0, page_off};
  assign beats_to_4k = 17'(bytes_to_4k >> OFF);
  assign rem_ext     = 17'(remaining);

  always_comb begin
    lim = rem_ext;
    if (17'(MAX_BURST_BEATS) < lim) lim = 17'(MAX_BURST_BEATS);
    if (beats_to_4k < lim) lim = beats_to_4k;
  end

  assign n = 9'(lim);

endmodule

// File: rtl/axi_to_fifo.sv
// Read-DMA: fetches [addr, addr+len) over AXI4 AR/R and pushes each beat into a FIFO.
// Define AXI_TO_FIFO_RRESP_CHECK_EN to flag non-OKAY read responses on error.
module axi_to_fifo
  import axi_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH  = 32,
  parameter int unsigned AXI_DATA_WIDTH  = 64,
  parameter int unsigned MAX_BURST_BEATS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [AXI_ADDR_WIDTH-1:0] addr,
  input  logic [15:0]               len,
  output logic                      busy,
  output logic                      error,
  output logic [AXI_ADDR_WIDTH-1:0] araddr,
  output logic [7:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [AXI_DATA_WIDTH-1:0] rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  input  logic                      rvalid,
  output logic                      rready,
  output logic                      fifo_wr_en,
  output logic [AXI_DATA_WIDTH-1:0] fifo_wr_data,
  input  logic                      fifo_full
);

  localparam int unsigned BYTES = AXI_DATA_WIDTH / 8;
  localparam int unsigned OFF   = $clog2(BYTES);
  localparam int unsigned CW    = 17 - OFF;

  axi_to_fifo_state_t state_q, state_d;

  logic [AXI_ADDR_WIDTH-1:0] cur_addr_q, araddr_q, ar_src;
  logic [CW-1:0]             remaining_q, beats_in, split_rem;
  logic [7:0]                arlen_q;
  logic [8:0]                split_n, burst_beats;
  logic [16:0]               len_round;
  logic                      start_ok, ar_fire, beat, load_ar;

  assign len_round   = {1'b0, len} + 17'(BYTES - 1);
  assign beats_in    = CW'(len_round >> OFF);
  assign start_ok    = (state_q == IDLE) && start && (len != 16'd0);
  assign ar_fire     = arvalid && arready;
  assign beat        = rvalid && rready;
  assign burst_beats = {1'b0, arlen_q} + 9'd1;

  // The next burst is sized from the incoming request in IDLE, else from the running cursor.
  assign load_ar   = start_ok || ((state_q == DATA) && beat && rlast && (remaining_q != '0));
  assign ar_src    = (state_q == IDLE) ? addr : cur_addr_q;
  assign split_rem = (state_q == IDLE) ? beats_in : remaining_q;

  axi_burst_splitter #(
    .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
    .MAX_BURST_BEATS(MAX_BURST_BEATS),
    .CNT_WIDTH      (CW)
  ) u_splitter (
    .page_off (ar_src[11:0]),
    .remaining(split_rem),
    .n        (split_n)
  );

  always_comb begin
    state_d = state_q;
    arvalid = 1'b0;
    rready  = 1'b0;
    unique case (state_q)
      IDLE: if (start_ok) state_d = ADDR;
      ADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = DATA;
      end
      DATA: begin
        rready = !fifo_full;
        if (rvalid && !fifo_full && rlast) state_d = (remaining_q == '0) ? IDLE : ADDR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      araddr_q    <= '0;
      arlen_q     <= '0;
    end else begin
      state_q <= state_d;
      if (load_ar) begin
        araddr_q <= ar_src;
        arlen_q  <= 8'(split_n - 9'd1);
      end
      if (start_ok) begin
        cur_addr_q  <= addr;
        remaining_q <= beats_in;
      end else if (ar_fire) begin
        cur_addr_q  <= araddr_q + (AXI_ADDR_WIDTH'(burst_beats) << OFF);
        remaining_q <= remaining_q - CW'(burst_beats);
      end
    end
  end

`ifdef AXI_TO_FIFO_RRESP_CHECK_EN
  logic error_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_q <= 1'b0;
    end else if (start_ok) begin
      error_q <= 1'b0;
    end else if (beat && (rresp != AXI_RESP_OKAY)) begin
      error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  logic unused_rresp;
  assign unused_rresp = ^rresp;
  assign error        = 1'b0;
`endif

  assign busy         = (state_q != IDLE);
  assign araddr       = araddr_q;
  assign arlen        = arlen_q;
  assign arsize       = 3'(OFF);
  assign arburst      = AXI_BURST_INCR;
  assign fifo_wr_en   = beat;
  assign fifo_wr_data = rdata;

endmodule
